prog_loader: RTL and testbench

- Byte-stream program loader: the write-side counterpart of the core's instruction fetch path.
- Holds the processor core in reset while it receives a framed program image over a valid/ready byte interface.
- Writes each assembled instruction word into instruction memory, verifies an XOR checksum, then releases the core.
- Sits beside `top`, driving the instruction-memory write port and the core-hold input.

---
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader.
// Receives a framed program image (length, big-endian words, XOR checksum)
// over a valid/ready byte interface, writes each assembled word into
// instruction memory and keeps the core held until the image verifies.
module prog_loader #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_loaded
);

   localparam int BPW = DATA_W / 8;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   state_t            state;
   logic [7:0]        len_hi;
   logic [15:0]       len;
   logic [7:0]        csum;
   logic [BCW-1:0]    byte_cnt;
   logic [DATA_W-1:0] asm_word;

   logic              xfer;
   logic [DATA_W-1:0] next_word;
   logic [16:0]       len_rx;

   // A byte moves only when both sides agree; words assemble MSB-first.
   assign xfer      = s_valid & s_ready;
   assign next_word = (asm_word << 8) | DATA_W'(s_data);
   assign len_rx    = {1'b0, len_hi, s_data};

   // Frame-parsing FSM with all outputs registered; words_loaded doubles as
   // the index of the next word to write since it steps with each strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         s_ready      <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_hold     <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
         len_hi       <= '0;
         len          <= '0;
         csum         <= '0;
         byte_cnt     <= '0;
         asm_word     <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state        <= LEN_HI;
                  s_ready      <= 1'b1;
                  busy         <= 1'b1;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  words_loaded <= '0;
                  csum         <= '0;
                  byte_cnt     <= '0;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_hi <= s_data;
                  csum   <= csum ^ s_data;
                  state  <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len  <= len_rx[15:0];
                  csum <= csum ^ s_data;
                  if (len_rx > MAX_LEN) begin
                     state    <= ERR;
                     s_ready  <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     cpu_hold <= 1'b1;
                  end else if (len_rx == 17'd0) begin
                     state <= CSUM;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  csum     <= csum ^ s_data;
                  asm_word <= next_word;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt     <= '0;
                     imem_we      <= 1'b1;
                     imem_addr    <= ADDR_W'(words_loaded);
                     imem_wdata   <= next_word;
                     words_loaded <= words_loaded + 16'd1;
                     if (words_loaded + 16'd1 == len) begin
                        state <= CSUM;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  if (s_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= ERR;
                     err      <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized
// frames, checked against a frame-level reference model.
module tb_prog_loader;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 256;

   logic              clk;
   logic              reset;
   logic              start;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;
   logic [15:0]       words_loaded;

   prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .imem_we(imem_we),
      .imem_addr(imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold),
      .busy(busy),
      .done(done),
      .err(err),
      .words_loaded(words_loaded)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so write timing can be related to byte transfers
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          obs_cyc[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          xfer_cyc[$];
   logic [7:0]  frame_q[$];

   // Capture every write strobe on the falling edge, away from updates
   always @(negedge clk) begin
      if (reset && imem_we) begin
         obs_cyc.push_back(cyc);
         obs_addr.push_back(32'(imem_addr));
         obs_data.push_back(imem_wdata);
      end
   end

   int n_pass   = 0;
   int n_checks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Offer one byte after 'gap' idle cycles; records the edge it transfers on
   task automatic applyStimulus(input logic [7:0] b, input int gap, input bit poke_start);
      repeat (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      start   = poke_start;
      for (int t = 0; t < 40; t++) begin
         if (s_ready) begin
            xfer_cyc.push_back(cyc + 1);
            @(negedge clk);
            start = 1'b0;
            return;
         end
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("ready_timeout", 32'(s_ready), 32'd1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
      checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      checkOutput({tag, "_imem_wdata"}, imem_wdata, 32'd0);
      checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   task automatic doStart(input string tag);
      s_valid = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
      checkOutput({tag, "_start_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_start_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_start_words"}, 32'(words_loaded), 32'd0);
      checkOutput({tag, "_start_ready"}, 32'(s_ready), 32'd1);
   endtask

   // Random frame of n words; optionally with a corrupted checksum
   task automatic buildFrame(input int n, input bit bad_csum);
      logic [7:0] x;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(8'(n >> 8));
      frame_q.push_back(8'(n));
      for (int k = 0; k < n * 4; k++) begin
         b = 8'($urandom);
         frame_q.push_back(b);
      end
      x = 8'h00;
      foreach (frame_q[i]) x = x ^ frame_q[i];
      if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
      frame_q.push_back(x);
   endtask

   // Send frame_q and compare everything against the frame-level model
   task automatic runFrame(input string tag, input int gapmode, input bit poke);
      int          n;
      bit          len_bad;
      logic [7:0]  x;
      bit          exp_done;
      int          exp_words;
      int          nw;
      logic [31:0] w;
      int          gap;
      obs_cyc.delete();
      obs_addr.delete();
      obs_data.delete();
      xfer_cyc.delete();
      doStart(tag);
      foreach (frame_q[i]) begin
         gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : $urandom_range(0, 2);
         applyStimulus(frame_q[i], gap, poke && (i == 3));
      end
      s_valid = 1'b0;
      checkOutput({tag, "_ready_after"}, 32'(s_ready), 32'd0);
      repeat (2) @(negedge clk);

      n       = {24'd0, frame_q[0], frame_q[1]};
      len_bad = (n > MAX_WORDS);
      if (len_bad) begin
         exp_done  = 1'b0;
         exp_words = 0;
      end else begin
         x = 8'h00;
         for (int i = 0; i < frame_q.size() - 1; i++) x = x ^ frame_q[i];
         exp_done  = (frame_q[frame_q.size() - 1] == x);
         exp_words = n;
      end

      checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
      checkOutput({tag, "_err"}, 32'(err), 32'(!exp_done));
      checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_ready"}, 32'(s_ready), 32'd0);
      checkOutput({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
      checkOutput({tag, "_nwrites"}, 32'(obs_data.size()), 32'(exp_words));

      nw = (obs_data.size() < exp_words) ? obs_data.size() : exp_words;
      for (int k = 0; k < nw; k++) begin
         w = {frame_q[2 + 4 * k], frame_q[3 + 4 * k], frame_q[4 + 4 * k], frame_q[5 + 4 * k]};
         checkOutput($sformatf("%s_addr%0d", tag, k), obs_addr[k], 32'(k));
         checkOutput($sformatf("%s_data%0d", tag, k), obs_data[k], w);
         checkOutput($sformatf("%s_when%0d", tag, k), 32'(obs_cyc[k]), 32'(xfer_cyc[5 + 4 * k]));
      end
   endtask

   // Directed sequence followed by randomized frames
   initial begin
      int n;
      reset   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (3) @(negedge clk);
      checkReset("por");
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] frame 1: two words, good checksum");
      frame_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
      runFrame("f1", 0, 1'b0);

      $display("[TB] frame 2: bad checksum");
      frame_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
      runFrame("f2", 0, 1'b0);

      $display("[TB] frame 3: empty image");
      frame_q = '{8'h00, 8'h00, 8'h00};
      runFrame("f3", 0, 1'b0);

      $display("[TB] frame 4: length too large");
      frame_q = '{8'h01, 8'h01};
      runFrame("f4", 0, 1'b0);

      $display("[TB] frame 5: alternating valid");
      frame_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
      runFrame("f5", 1, 1'b1);

      $display("[TB] frame 6: reset mid-load then reload");
      obs_data.delete();
      xfer_cyc.delete();
      doStart("f6a");
      for (int i = 0; i < 7; i++) applyStimulus(frame_q[i], 0, 1'b0);
      s_valid = 1'b0;
      reset   = 1'b0;
      #1;
      checkReset("midrst");
      @(negedge clk);
      checkReset("midrst_hold");
      reset = 1'b1;
      @(negedge clk);
      runFrame("f6", 0, 1'b0);

      $display("[TB] randomized frames");
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 5) == 0) begin
            n = $urandom_range(257, 65535);
            frame_q.delete();
            frame_q.push_back(8'(n >> 8));
            frame_q.push_back(8'(n));
         end else begin
            buildFrame($urandom_range(0, 5), 1'($urandom_range(0, 1)));
         end
         runFrame($sformatf("r%0d", r), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
